register_write_controller: RTL and testbench

REGISTER_WRITE_CONTROLLER -- requirements
Module: register_write_controller

---
 rtl/synth_pkg.sv | 16 +
 rtl/register_write_fifo.sv | 69 ++++++
 rtl/register_write_controller.sv | 112 +++++++++++
 tb/tb_register_write_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth parameter-write path: target decode and buffer sizing.
package synth_pkg;

  typedef enum logic [3:0] {
    TargetOperator = 4'd0,
    TargetEnvelope = 4'd1,
    TargetGlobal   = 4'd2
  } target_e;

  // Target field position within the 16-bit command register number
  localparam int unsigned TargetMsb        = 15;
  localparam int unsigned TargetLsb        = 12;
  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned EntryWidth       = 32;

endpackage

// File: rtl/register_write_fifo.sv
// Pending-write buffer: circular FIFO with synchronous active-low reset and no
// empty-bypass, so a freshly pushed entry is only visible from the next cycle.
module register_write_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/register_write_controller.sv
// Turns SPI register-write commands into one-cycle parameter-memory write strobes,
// buffering them while the synth core owns the memories.
module register_write_controller
  import synth_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_RegisterWriteEnable,
  input  logic [15:0]           i_RegisterWriteNumber,
  input  logic [15:0]           i_RegisterWriteValue,
  input  logic                  i_CoreBusy,
  output logic                  o_OperatorWriteEnable,
  output logic                  o_EnvelopeWriteEnable,
  output logic                  o_GlobalWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_ParamWriteAddress,
  output logic [15:0]           o_ParamWriteValue,
  output logic                  o_InvalidWrite,
  output logic                  o_Overflow,
  output logic                  o_Pending
);

  logic                  prev_en_q, prev_en_d;
  logic                  op_we_q, op_we_d, env_we_q, env_we_d, glb_we_q, glb_we_d;
  logic                  inv_q, inv_d, ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           value_q, value_d;

  logic                  cmd_edge, fifo_full, fifo_empty, pop;
  logic [EntryWidth-1:0] head;
  logic [15:0]           head_number, head_value;
  logic [3:0]            head_target;

  assign cmd_edge    = i_RegisterWriteEnable & ~prev_en_q;
  assign pop         = ~fifo_empty & ~i_CoreBusy;
  assign head_number = head[31:16];
  assign head_value  = head[15:0];
  assign head_target = head_number[TargetMsb:TargetLsb];

  register_write_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryWidth)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Reset),
    .push_i  (cmd_edge),
    .pop_i   (pop),
    .wdata_i ({i_RegisterWriteNumber, i_RegisterWriteValue}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  always_comb begin
    prev_en_d = i_RegisterWriteEnable;
    op_we_d   = 1'b0;
    env_we_d  = 1'b0;
    glb_we_d  = 1'b0;
    inv_d     = 1'b0;
    addr_d    = addr_q;
    value_d   = value_q;
    ovf_d     = ovf_q | (cmd_edge & fifo_full & ~pop);
    if (pop) begin
      // Address/value only move with a real strobe; an invalid target leaves them alone
      case (head_target)
        TargetOperator: op_we_d  = 1'b1;
        TargetEnvelope: env_we_d = 1'b1;
        TargetGlobal:   glb_we_d = 1'b1;
        default:        inv_d    = 1'b1;
      endcase
      if (!inv_d) begin
        addr_d  = head_number[ADDR_WIDTH-1:0];
        value_d = head_value;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      // Enable held high across reset release must not look like a fresh command
      prev_en_q <= 1'b1;
      op_we_q   <= 1'b0;
      env_we_q  <= 1'b0;
      glb_we_q  <= 1'b0;
      inv_q     <= 1'b0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      value_q   <= '0;
    end else begin
      prev_en_q <= prev_en_d;
      op_we_q   <= op_we_d;
      env_we_q  <= env_we_d;
      glb_we_q  <= glb_we_d;
      inv_q     <= inv_d;
      ovf_q     <= ovf_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
    end
  end

  assign o_OperatorWriteEnable = op_we_q;
  assign o_EnvelopeWriteEnable = env_we_q;
  assign o_GlobalWriteEnable   = glb_we_q;
  assign o_InvalidWrite        = inv_q;
  assign o_Overflow            = ovf_q;
  assign o_ParamWriteAddress   = addr_q;
  assign o_ParamWriteValue     = value_q;
  assign o_Pending             = ~fifo_empty;

endmodule

// File: tb/tb_register_write_controller.sv
// Scoreboard bench for register_write_controller: stimulus queues expected strobes,
// a monitor pops and compares whenever a strobe or invalid pulse appears.
module tb_register_write_controller;

  localparam int KOp  = 0;
  localparam int KEnv = 1;
  localparam int KGlb = 2;
  localparam int KInv = 3;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [15:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] number = '0;
  logic [15:0] value = '0;
  logic        busy = 1'b0;
  logic        op_we, env_we, glb_we, inv, ovf, pend;
  logic [11:0] addr;
  logic [15:0] data;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  register_write_controller #(
    .FIFO_DEPTH (4),
    .ADDR_WIDTH (12)
  ) dut (
    .i_Clock               (clk),
    .i_Reset               (rst_n),
    .i_RegisterWriteEnable (en),
    .i_RegisterWriteNumber (number),
    .i_RegisterWriteValue  (value),
    .i_CoreBusy            (busy),
    .o_OperatorWriteEnable (op_we),
    .o_EnvelopeWriteEnable (env_we),
    .o_GlobalWriteEnable   (glb_we),
    .o_ParamWriteAddress   (addr),
    .o_ParamWriteValue     (data),
    .o_InvalidWrite        (inv),
    .o_Overflow            (ovf),
    .o_Pending             (pend)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_strobe(input int kind, input logic [11:0] a, input logic [15:0] v,
                               input int due);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.val  = v;
    e.due  = due;
    sbq.push_back(e);
  endtask

  // One command: rising edge of enable for one cycle, optional expected strobe
  task automatic send(input logic [15:0] num, input logic [15:0] v, input int kind,
                      input logic [11:0] a, input bit exp_it, input bit timed);
    @(negedge clk);
    en     = 1'b1;
    number = num;
    value  = v;
    if (exp_it) expect_strobe(kind, a, v, timed ? cyc + 2 : -1);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  // Monitor
  initial begin
    int   n;
    int   kind;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n = int'(op_we === 1'b1) + int'(env_we === 1'b1) + int'(glb_we === 1'b1)
        + int'(inv === 1'b1);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL onehot got %0d active strobes expected at most 1 (cyc %0d)", n, cyc);
      end else if (n == 1) begin
        kind = (op_we === 1'b1) ? KOp : (env_we === 1'b1) ? KEnv
             : (glb_we === 1'b1) ? KGlb : KInv;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe got kind %0d addr %h val %h expected none (cyc %0d)",
                   kind, addr, data, cyc);
        end else begin
          e = sbq.pop_front();
          if (kind != e.kind || (e.due >= 0 && cyc != e.due) ||
              (kind != KInv && (addr !== e.addr || data !== e.val))) begin
            errors++;
            $display("FAIL strobe got kind %0d addr %h val %h cyc %0d expected kind %0d addr %h val %h cyc %0d",
                     kind, addr, data, cyc, e.kind, e.addr, e.val, e.due);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {28'd0, op_we, env_we, glb_we, inv}, 32'd0);
    chk("reset_flags", {30'd0, ovf, pend}, 32'd0);
    chk("reset_addr", {20'd0, addr}, 32'd0);
    chk("reset_value", {16'd0, data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operator write with latency 2
    send(16'h0005, 16'hBEEF, KOp, 12'h005, 1'b1, 1'b1);
    drain("drain_basic");

    // Held-high enable produces exactly one strobe
    @(negedge clk);
    en     = 1'b1;
    number = 16'h0012;
    value  = 16'h1234;
    expect_strobe(KOp, 12'h012, 16'h1234, cyc + 2);
    repeat (20) @(negedge clk);
    en = 1'b0;
    drain("drain_held");

    // Invalid target, then global
    send(16'h7ABC, 16'h5555, KInv, 12'h000, 1'b1, 1'b0);
    send(16'h2003, 16'h0F0F, KGlb, 12'h003, 1'b1, 1'b0);
    drain("drain_inv_glb");

    // Full buffer: simultaneous push and pop keeps all entries
    busy = 1'b1;
    for (int i = 1; i <= 4; i++)
      send(16'h0100 + 16'(i), 16'hC000 + 16'(i), KOp, 12'h100 + 12'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("full_pending", {31'd0, pend}, 32'd1);
    en     = 1'b1;
    number = 16'h0105;
    value  = 16'hC005;
    busy   = 1'b0;
    expect_strobe(KOp, 12'h105, 16'hC005, -1);
    @(negedge clk);
    en   = 1'b0;
    busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pushpop_no_overflow", {31'd0, ovf}, 32'd0);
    chk("pushpop_pending", {31'd0, pend}, 32'd1);
    busy = 1'b0;
    drain("drain_pushpop");
    chk("pushpop_empty", {31'd0, pend}, 32'd0);

    // Overflow: fifth command dropped, then four back-to-back envelope strobes
    busy = 1'b1;
    for (int i = 1; i <= 5; i++)
      send(16'h1000 + 16'(i), 16'hA000 + 16'(i), KEnv, 12'h000, 1'b0, 1'b0);
    chk("overflow_set", {31'd0, ovf}, 32'd1);
    chk("overflow_pending", {31'd0, pend}, 32'd1);
    @(negedge clk);
    busy = 1'b0;
    for (int i = 0; i < 4; i++)
      expect_strobe(KEnv, 12'(i + 1), 16'hA001 + 16'(i), cyc + 1 + i);
    drain("drain_overflow");
    chk("overflow_sticky", {31'd0, ovf}, 32'd1);

    // Reset with pending entries and enable high
    busy = 1'b1;
    for (int i = 1; i <= 3; i++)
      send(16'h0200 + 16'(i), 16'hD000 + 16'(i), KOp, 12'h000, 1'b0, 1'b0);
    chk("prereset_pending", {31'd0, pend}, 32'd1);
    @(negedge clk);
    en     = 1'b1;
    number = 16'h0333;
    value  = 16'h3333;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_strobes", {28'd0, op_we, env_we, glb_we, inv}, 32'd0);
    chk("rst2_flags", {30'd0, ovf, pend}, 32'd0);
    chk("rst2_addr_value", {4'd0, addr, data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy  = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_after_reset_pending", {31'd0, pend}, 32'd0);
    en = 1'b0;
    send(16'h0007, 16'h7777, KOp, 12'h007, 1'b1, 1'b1);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
